shared_mem_ctrl: RTL and testbench

Shared data-memory responder: the memory end of the core's load/store port (`enable`/`addr`/`wr_data` in, `rd_data`/`val` out). It serves `CORE_COUNT` cores from one single-port byte memory. A round-robin arbiter picks one pending request, performs it, and acknowledges the winning core with a one-cycle `val` pulse.

---
 rtl/shared_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_shared_mem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_ctrl.sv
// Shared single-port byte memory serving CORE_COUNT load/store ports.
// Round-robin arbitration; every access walks IDLE -> ACCESS -> RESP.
//   state    | meaning
//   S_IDLE   | arbitrate pending ports, latch the winning request
//   S_ACCESS | perform the latched read or write
//   S_RESP   | pulse val for the granted port, update round-robin pointer
module shared_mem_ctrl #(
    parameter int CORE_COUNT = 4,
    parameter int ADDR_SIZE  = 12,
    parameter int REG_SIZE   = 8,
    localparam int GW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2*CORE_COUNT-1:0]        enable,
    input  logic [ADDR_SIZE*CORE_COUNT-1:0] addr,
    input  logic [REG_SIZE*CORE_COUNT-1:0] wr_data,
    output logic [REG_SIZE*CORE_COUNT-1:0] rd_data,
    output logic [CORE_COUNT-1:0]          val,
    output logic                           busy,
    output logic [GW-1:0]                  grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                          state_q, state_d;
    logic [GW-1:0]                   last_grant_q, last_grant_d;
    logic [GW-1:0]                   grant_id_q, grant_id_d;
    logic                            op_wr_q, op_wr_d;
    logic [ADDR_SIZE-1:0]            addr_q, addr_d;
    logic [REG_SIZE-1:0]             wdata_q, wdata_d;
    logic [REG_SIZE*CORE_COUNT-1:0]  rd_data_q, rd_data_d;

    logic [REG_SIZE-1:0]             mem [2**ADDR_SIZE];
    logic [REG_SIZE-1:0]             mem_rdata;
    logic                            mem_we;

    logic [CORE_COUNT-1:0]           pending;
    logic                            any_pending;
    logic [GW-1:0]                   win_id;
    int                              idx;

    always_comb begin
        pending = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            pending[i] = (enable[2*i +: 2] == 2'b01) || (enable[2*i +: 2] == 2'b10);
        end
    end

    // Scan from farthest to nearest so the port closest after last_grant wins.
    always_comb begin
        any_pending = 1'b0;
        win_id      = '0;
        idx         = 0;
        for (int i = CORE_COUNT; i >= 1; i--) begin
            idx = (int'(last_grant_q) + i) % CORE_COUNT;
            if (pending[idx]) begin
                any_pending = 1'b1;
                win_id      = GW'(idx);
            end
        end
    end

    assign mem_rdata = mem[addr_q];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        op_wr_d      = op_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_pending) begin
                    grant_id_d = win_id;
                    op_wr_d    = (enable[2*win_id +: 2] == 2'b10);
                    addr_d     = addr[win_id*ADDR_SIZE +: ADDR_SIZE];
                    wdata_d    = wr_data[win_id*REG_SIZE +: REG_SIZE];
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (op_wr_q) begin
                    mem_we = 1'b1;
                end else begin
                    rd_data_d[grant_id_q*REG_SIZE +: REG_SIZE] = mem_rdata;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                last_grant_d = grant_id_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(CORE_COUNT - 1);
            grant_id_q   <= '0;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Memory is not reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        val = '0;
        if (state_q == S_RESP) begin
            val[grant_id_q] = 1'b1;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_id_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Scoreboard bench for shared_mem_ctrl: expectations queued at issue,
// retired against val pulses; byte-memory reference model in the bench.
module tb_shared_mem_ctrl;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [2*NC-1:0]   enable;
    logic [AW*NC-1:0]  addr;
    logic [DW*NC-1:0]  wr_data;
    logic [DW*NC-1:0]  rd_data;
    logic [NC-1:0]     val;
    logic              busy;
    logic [1:0]        grant_id;

    shared_mem_ctrl #(.CORE_COUNT(NC), .ADDR_SIZE(AW), .REG_SIZE(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .val(val), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        bit         rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [7:0]  model   [4096];
    bit          written [4096];
    logic [7:0]  last_rd   [NC];
    bit          done_f    [NC];
    int          last_val  [NC];
    int          remaining [NC];
    bit          sustain = 1'b0;
    bit          gap_on  = 1'b0;
    logic [NC-1:0] prev_val = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input int p, input logic [1:0] op, input logic [11:0] a, input logic [7:0] d);
        enable[2*p +: 2]   = op;
        addr[AW*p +: AW]   = a;
        wr_data[DW*p +: DW] = d;
    endtask

    task automatic issue(input int p, input bit rd, input logic [11:0] a, input logic [7:0] d,
                         input int ecyc);
        exp_t e;
        drive(p, rd ? 2'b01 : 2'b10, a, d);
        e.port = p;
        e.rd   = rd;
        e.cyc  = ecyc;
        e.data = rd ? model[a] : d;
        if (!rd) begin
            model[a]   = d;
            written[a] = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // Each port works in its own 16-byte region so issue-time expectations hold.
    task automatic issue_rand(input int p);
        logic [11:0] a;
        bit          rd;
        a  = 12'h800 | 12'(p << 4) | 12'($urandom_range(15));
        rd = ($urandom_range(1) == 1) && written[a];
        issue(p, rd, a, 8'($urandom), -1);
        remaining[p]--;
    endtask

    task automatic sample();
        int   idx;
        int   gap;
        exp_t e;
        if (val != '0) begin
            chk("val_onehot", $countones(val), 1);
            chk("val_width", 32'(prev_val), 0);
        end
        for (int i = 0; i < NC; i++) begin
            if (val[i]) begin
                idx = -1;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (exp_q[k].port == i && idx < 0) idx = k;
                end
                if (idx < 0) begin
                    chk("val_unexpected", 32'(val), 0);
                end else begin
                    e = exp_q[idx];
                    exp_q.delete(idx);
                    chk("grant_id", 32'(grant_id), i);
                    if (e.cyc >= 0) chk("val_cycle", cyc, e.cyc);
                    if (e.rd) begin
                        chk("rd_data", 32'(rd_data[DW*i +: DW]), 32'(e.data));
                        last_rd[i] = e.data;
                    end
                    if (gap_on && last_val[i] >= 0) begin
                        gap = cyc - last_val[i];
                        chk("svc_gap_over12", 32'(gap > 12), 0);
                    end
                    last_val[i] = cyc;
                    done_f[i]   = 1'b1;
                end
            end
        end
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                chk("rd_hold", 32'(rd_data[DW*i +: DW]), 32'(last_rd[i]));
            end
        end
        prev_val = val;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NC; i++) begin
            if (done_f[i]) begin
                done_f[i] = 1'b0;
                drive(i, 2'b00, '0, '0);
                if (sustain && remaining[i] > 0) issue_rand(i);
            end
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            step();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            last_rd[i]   = '0;
            done_f[i]    = 1'b0;
            last_val[i]  = -1;
            remaining[i] = 0;
        end
        reset   = 1'b1;
        enable  = '0;
        addr    = '0;
        wr_data = '0;
        repeat (3) step();
        reset = 1'b0;
        cyc   = 0;

        chk("rst_val", 32'(val), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_rd_data", rd_data, 0);

        // Simultaneous writes after reset, then simultaneous read-back.
        for (int i = 0; i < NC; i++) issue(i, 1'b0, 12'(i), 8'(16 + i), 2 + 3*i);
        wait_done(40);
        for (int i = 0; i < NC; i++) issue(i, 1'b1, 12'(i), 8'h00, cyc + 2 + 3*i);
        wait_done(40);

        // Single write then read.
        issue(0, 1'b0, 12'h123, 8'hA5, cyc + 2);
        wait_done(20);
        issue(0, 1'b1, 12'h123, 8'h00, cyc + 2);
        wait_done(20);
        chk("rd0_a5", 32'(rd_data[7:0]), 32'h A5);

        // Reserved code is never served; other ports unaffected.
        drive(1, 2'b11, 12'h005, 8'h77);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("busy_reserved", 32'(busy), 0);
        end
        issue(2, 1'b1, 12'h000, 8'h00, cyc + 2);
        wait_done(20);
        chk("rd0_isolated", 32'(rd_data[7:0]), 32'h A5);
        chk("rd2_value", 32'(rd_data[23:16]), 32'h10);

        // Core 2 served last: core 3 must beat core 1.
        issue(1, 1'b1, 12'h003, 8'h00, cyc + 5);
        issue(3, 1'b1, 12'h123, 8'h00, cyc + 2);
        wait_done(20);

        // Reset on the ACCESS edge of a write drops the write.
        issue(0, 1'b0, 12'h010, 8'h55, cyc + 2);
        wait_done(20);
        drive(0, 2'b10, 12'h010, 8'hFF);
        step();
        reset = 1'b1;
        drive(0, 2'b00, '0, '0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < NC; i++) last_rd[i] = '0;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_val", 32'(val), 0);
        issue(0, 1'b1, 12'h010, 8'h00, cyc + 2);
        wait_done(20);

        // Sustained random load on all ports.
        for (int i = 0; i < NC; i++) begin
            last_val[i]  = -1;
            remaining[i] = 100;
        end
        sustain = 1'b1;
        gap_on  = 1'b1;
        for (int i = 0; i < NC; i++) issue_rand(i);
        wait_done(3000);
        sustain = 1'b0;
        gap_on  = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
